// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. One external full adder is reused
// for all operand bits, LSB first, one bit per clock. Start is edge-triggered and
// the result is held on sum/cout until the next add completes.
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             start_q;
  logic             launch;
  logic             last_bit;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [IDX_W-1:0] idx;

  // A button already held when reset releases must not launch, hence start_q
  // resets high and a launch needs a genuine low-to-high transition in IDLE.
  assign launch   = start & ~start_q & (state == S_IDLE);
  assign last_bit = (idx == LAST_IDX);

  // Result bits enter at the MSB and walk down, so after WIDTH shifts bit 0 of
  // the operands has landed in bit 0 of the accumulator.
  always_comb begin
    acc_nxt = acc >> 1;
    acc_nxt[WIDTH-1] = fa_sum;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: the full adder inputs are gated to zero whenever no add is running.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      S_RUN: begin
        fa_a   = a_sh[0];
        fa_b   = b_sh[0];
        fa_cin = carry;
        busy   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand shifting, carry chaining and result capture. sum/cout only move on
  // the final bit so the LEDs never show a partially built result.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b1;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      start_q <= start;
      if (launch) begin
        a_sh  <= a;
        b_sh  <= b;
        acc   <= '0;
        carry <= 1'b0;
        idx   <= '0;
      end else if (state == S_RUN) begin
        acc   <= acc_nxt;
        carry <= fa_cout;
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        idx   <= idx + IDX_W'(1);
        if (last_bit) begin
          sum  <= acc_nxt;
          cout <= fa_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a WIDTH=4 and a WIDTH=2 instance, each paired with
// a behavioural full adder. Expected sums are queued at launch and compared when
// done pulses.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start4, fa_a4, fa_b4, fa_cin4, fa_sum4, fa_cout4, cout4, busy4, done4;
  logic [3:0] a4, b4, sum4;
  logic       start2, fa_a2, fa_b2, fa_cin2, fa_sum2, fa_cout2, cout2, busy2, done2;
  logic [1:0] a2, b2, sum2;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt4 = 0;
  int done_cnt2 = 0;
  logic [4:0] q4[$];
  logic [2:0] q2[$];
  logic [4:0] prev4;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4),
    .fa_sum(fa_sum4), .fa_cout(fa_cout4),
    .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .fa_a(fa_a2), .fa_b(fa_b2), .fa_cin(fa_cin2),
    .fa_sum(fa_sum2), .fa_cout(fa_cout2),
    .sum(sum2), .cout(cout2), .busy(busy2), .done(done2)
  );

  assign fa_sum4  = fa_a4 ^ fa_b4 ^ fa_cin4;
  assign fa_cout4 = (fa_a4 & fa_b4) | (fa_cin4 & (fa_a4 ^ fa_b4));
  assign fa_sum2  = fa_a2 ^ fa_b2 ^ fa_cin2;
  assign fa_cout2 = (fa_a2 & fa_b2) | (fa_cin2 & (fa_a2 ^ fa_b2));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, want, $time);
    end
  endtask

  // Scoreboard for the 4-bit instance.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      done_cnt4++;
      if (q4.size() == 0) chk("unexpected_done4", 1, 0);
      else chk("result4", {cout4, sum4}, q4.pop_front());
    end
  end

  // Scoreboard for the 2-bit instance.
  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      done_cnt2++;
      if (q2.size() == 0) chk("unexpected_done2", 1, 0);
      else chk("result2", {cout2, sum2}, q2.pop_front());
    end
  end

  // One full add on the 4-bit instance with handshake timing checks.
  task automatic do_add4(input logic [3:0] av, input logic [3:0] bv);
    logic [4:0] want;
    want = 5'(av) + 5'(bv);
    @(posedge clk); #1;
    a4 = av; b4 = bv; start4 = 1'b1;
    q4.push_back(want);
    @(posedge clk);  // launch edge
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy4_run", busy4, 1);
      chk("done4_early", done4, 0);
      chk("sum4_hold", {cout4, sum4}, prev4);
    end
    @(negedge clk);
    chk("done4_pulse", done4, 1);
    chk("busy4_done", busy4, 0);
    @(negedge clk);
    chk("done4_one_cycle", done4, 0);
    prev4 = want;
    #1 start4 = 1'b0;
  endtask

  task automatic do_add2(input logic [1:0] av, input logic [1:0] bv);
    logic [2:0] want;
    want = 3'(av) + 3'(bv);
    @(posedge clk); #1;
    a2 = av; b2 = bv; start2 = 1'b1;
    q2.push_back(want);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("busy2_run", busy2, 1);
    end
    @(negedge clk);
    chk("done2_pulse", done2, 1);
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; start4 = 1'b0; start2 = 1'b0;
    a4 = '0; b4 = '0; a2 = '0; b2 = '0;
    prev4 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_sum", sum4, 0);
    chk("rst_cout", cout4, 0);
    chk("rst_fa_a", fa_a4, 0);

    // Basic adds, including both carry extremes.
    do_add4(4'd9, 4'd6);
    do_add4(4'd15, 4'd15);
    do_add4(4'd0, 4'd0);

    // Narrow instance.
    do_add2(2'b11, 2'b01);
    do_add2(2'b10, 2'b01);

    // Held start, extra edge and operand changes during RUN.
    base = done_cnt4;
    @(posedge clk); #1;
    a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
    q4.push_back(5'd8);
    @(posedge clk); #1;  // launch edge passed
    a4 = 4'd10; b4 = 4'd12; start4 = 1'b0;
    @(negedge clk);
    chk("hold_sum_run1", {cout4, sum4}, prev4);
    @(posedge clk); #1;
    a4 = 4'd15; start4 = 1'b1;
    @(negedge clk);
    chk("hold_sum_run2", {cout4, sum4}, prev4);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("held_start_one_done", done_cnt4 - base, 1);
    chk("held_start_idle", busy4, 0);
    prev4 = 5'd8;
    #1 start4 = 1'b0;

    // Reset in the second RUN cycle aborts with no done pulse.
    base = done_cnt4;
    @(posedge clk); #1;
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    @(posedge clk);       // launch
    @(posedge clk); #1;   // first RUN edge passed
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy4, 0);
    chk("abort_sum", sum4, 0);
    chk("abort_cout", cout4, 0);
    chk("abort_done", done4, 0);
    prev4 = '0;
    repeat (6) @(negedge clk);
    chk("abort_no_relaunch", busy4, 0);
    chk("abort_no_done", done_cnt4 - base, 0);
    #1 start4 = 1'b0;

    // Reset and a start edge in the same cycle: reset wins.
    @(posedge clk); #1;
    rst = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_beats_start", busy4, 0);
    #1 start4 = 1'b0;

    do_add4(4'd7, 4'd7);

    // Exhaustive operands.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_add4(4'(i), 4'(j));

    repeat (3) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("done2_count", done_cnt2, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
